// File: rtl/stream_arb_mux_if.sv
// Handshake bundle for stream_arb_mux: N request channels in, one registered stream out.
// "master" is the arbiter's view; "slave" is the surrounding sources and sink.
interface stream_arb_mux_if #(
    parameter int DATA_WIDTH   = 8,
    parameter int INPUT_NUMBER = 8
);
    localparam int SEL_W = $clog2(INPUT_NUMBER);

    logic [SEL_W-1:0]        select_i;
    logic [DATA_WIDTH-1:0]   data_i [INPUT_NUMBER];
    logic [INPUT_NUMBER-1:0] valid_i;
    logic [INPUT_NUMBER-1:0] last_i;
    logic [INPUT_NUMBER-1:0] ready_o;
    logic [DATA_WIDTH-1:0]   data_o;
    logic                    valid_o;
    logic                    last_o;
    logic                    ready_i;
    logic [SEL_W-1:0]        grant_o;

    modport master (
        input  select_i, data_i, valid_i, last_i, ready_i,
        output ready_o, data_o, valid_o, last_o, grant_o
    );

    modport slave (
        output select_i, data_i, valid_i, last_i, ready_i,
        input  ready_o, data_o, valid_o, last_o, grant_o
    );
endinterface

// File: rtl/stream_arb_mux.sv
// N-to-1 packet-locked stream arbiter with a registered output stage.
// Arbitration is round-robin (ARB_MODE=0) or by external select (ARB_MODE=1).
module stream_arb_mux #(
    parameter int DATA_WIDTH   = 8,
    parameter int INPUT_NUMBER = 8,
    parameter int ARB_MODE     = 0
) (
    input logic              clk_i,
    input logic              rst_i,
    stream_arb_mux_if.master bus
);
    localparam int SEL_W = $clog2(INPUT_NUMBER);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t                  state;
    logic [SEL_W-1:0]        grant;
    logic [SEL_W-1:0]        rr_ptr;
    logic [SEL_W:0]          pick;
    logic [INPUT_NUMBER-1:0] ready;
    logic                    out_free;
    logic                    accept;
    logic [DATA_WIDTH-1:0]   data_p1;
    logic                    last_p1;
    logic                    vld_p1;

    // Result is {found, index}; the first requester after prev wins, wrapping.
    function automatic logic [SEL_W:0] rr_pick(input logic [INPUT_NUMBER-1:0] req,
                                               input logic [SEL_W-1:0]        prev);
        logic [SEL_W:0] res;
        int             idx;
        res = '0;
        for (int i = INPUT_NUMBER; i >= 1; i--) begin
            idx = (int'(prev) + i) % INPUT_NUMBER;
            if (req[idx]) res = {1'b1, SEL_W'(idx)};
        end
        return res;
    endfunction

    function automatic logic [SEL_W:0] sel_pick(input logic [INPUT_NUMBER-1:0] req,
                                                input logic [SEL_W-1:0]        sel);
        logic [SEL_W:0] res;
        res = '0;
        if ((int'(sel) < INPUT_NUMBER) && req[sel]) res = {1'b1, sel};
        return res;
    endfunction

    always_comb begin
        pick = (ARB_MODE == 1) ? sel_pick(bus.valid_i, bus.select_i)
                               : rr_pick(bus.valid_i, rr_ptr);
    end

    assign out_free = !vld_p1 || bus.ready_i;
    assign accept   = (state == BUSY) && bus.valid_i[grant] && out_free;

    always_comb begin
        ready = '0;
        if (state == BUSY && out_free) ready[grant] = 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= IDLE;
            grant   <= '0;
            rr_ptr  <= SEL_W'(INPUT_NUMBER - 1);
            vld_p1  <= 1'b0;
            data_p1 <= '0;
            last_p1 <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick[SEL_W]) begin
                        grant  <= pick[SEL_W-1:0];
                        rr_ptr <= pick[SEL_W-1:0];
                        state  <= BUSY;
                    end
                end
                BUSY: begin
                    if (accept && bus.last_i[grant]) state <= IDLE;
                end
                default: state <= IDLE;
            endcase

            // Stage p1: output register, loaded on accept, drained by the sink
            if (accept) begin
                data_p1 <= bus.data_i[grant];
                last_p1 <= bus.last_i[grant];
                vld_p1  <= 1'b1;
            end else if (vld_p1 && bus.ready_i) begin
                vld_p1  <= 1'b0;
            end
        end
    end

    assign bus.ready_o = ready;
    assign bus.data_o  = data_p1;
    assign bus.last_o  = last_p1;
    assign bus.valid_o = vld_p1;
    assign bus.grant_o = grant;
endmodule

// File: tb/tb_stream_arb_mux.sv
// Directed bench for stream_arb_mux: one round-robin and one external-select instance,
// queue-driven sources and a capture of every output beat with its grant and cycle.
module tb_stream_arb_mux;
    typedef struct packed {
        logic [31:0] cyc;
        logic [2:0]  grant;
        logic        last;
        logic [7:0]  data;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    stream_arb_mux_if #(.DATA_WIDTH(8), .INPUT_NUMBER(8)) if0 ();
    stream_arb_mux_if #(.DATA_WIDTH(8), .INPUT_NUMBER(8)) if1 ();

    stream_arb_mux #(.DATA_WIDTH(8), .INPUT_NUMBER(8), .ARB_MODE(0)) dut_rr (
        .clk_i(clk), .rst_i(rst), .bus(if0));
    stream_arb_mux #(.DATA_WIDTH(8), .INPUT_NUMBER(8), .ARB_MODE(1)) dut_sel (
        .clk_i(clk), .rst_i(rst), .bus(if1));

    logic [8:0] q0 [8][$];
    logic [8:0] q1 [8][$];
    logic [7:0] hold0 = '0;
    logic [7:0] hold1 = '0;
    logic [7:0] fire0, fire1;
    beat_t      out0 [$];
    beat_t      out1 [$];
    logic [8:0] expq [$];
    int         cyc = 0;
    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] held;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic refresh();
        for (int k = 0; k < 8; k++) begin
            if (q0[k].size() > 0 && !hold0[k]) begin
                if0.valid_i[k] = 1'b1; if0.data_i[k] = q0[k][0][7:0]; if0.last_i[k] = q0[k][0][8];
            end else begin
                if0.valid_i[k] = 1'b0; if0.data_i[k] = '0; if0.last_i[k] = 1'b0;
            end
            if (q1[k].size() > 0 && !hold1[k]) begin
                if1.valid_i[k] = 1'b1; if1.data_i[k] = q1[k][0][7:0]; if1.last_i[k] = q1[k][0][8];
            end else begin
                if1.valid_i[k] = 1'b0; if1.data_i[k] = '0; if1.last_i[k] = 1'b0;
            end
        end
    endtask

    // One clock: present inputs, sample at negedge, pop accepted beats just after posedge.
    task automatic tick();
        refresh();
        @(negedge clk);
        if (if0.valid_o && if0.ready_i)
            out0.push_back('{32'(cyc), if0.grant_o, if0.last_o, if0.data_o});
        if (if1.valid_o && if1.ready_i)
            out1.push_back('{32'(cyc), if1.grant_o, if1.last_o, if1.data_o});
        fire0 = rst ? 8'h00 : (if0.valid_i & if0.ready_o);
        fire1 = rst ? 8'h00 : (if1.valid_i & if1.ready_o);
        @(posedge clk);
        #1;
        cyc++;
        for (int k = 0; k < 8; k++) begin
            if (fire0[k]) void'(q0[k].pop_front());
            if (fire1[k]) void'(q1[k].pop_front());
        end
    endtask

    task automatic run_until(input int which, input int n, input int budget, input string tag);
        int t;
        t = 0;
        while (((which == 0) ? out0.size() : out1.size()) < n && t < budget) begin
            tick();
            t++;
        end
        check(tag, (which == 0) ? out0.size() : out1.size(), n);
    endtask

    task automatic check_out(input int which, input string tag);
        beat_t b;
        int    n;
        n = (which == 0) ? out0.size() : out1.size();
        check({tag, "_count"}, n, expq.size());
        for (int i = 0; i < expq.size(); i++) begin
            b = '0;
            if (i < n) b = (which == 0) ? out0[i] : out1[i];
            check($sformatf("%s_beat%0d", tag, i), {23'd0, b.last, b.data}, {23'd0, expq[i]});
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        int t;
        if0.ready_i = 1'b1; if1.ready_i = 1'b1;
        if0.select_i = '0;  if1.select_i = '0;

        // Reset with every channel requesting a single-beat packet
        for (int k = 0; k < 8; k++) q0[k].push_back({1'b1, 8'hC0 + 8'(k)});
        for (int i = 0; i < 2; i++) begin
            tick();
            check("rst_valid", if0.valid_o, 0);
            check("rst_ready", if0.ready_o, 0);
            check("rst_grant", if0.grant_o, 0);
            check("rst_data", if0.data_o, 0);
        end
        rst = 1'b0;
        run_until(0, 8, 40, "rr_all_timeout");
        expq = '{9'h1C0, 9'h1C1, 9'h1C2, 9'h1C3, 9'h1C4, 9'h1C5, 9'h1C6, 9'h1C7};
        check_out(0, "rr_all");
        idle(3); out0.delete();

        // Round-robin order over channels 0, 3, 5
        q0[0].push_back(9'h00A); q0[0].push_back(9'h10B);
        q0[3].push_back(9'h03A); q0[3].push_back(9'h13B);
        q0[5].push_back(9'h05A); q0[5].push_back(9'h15B);
        run_until(0, 6, 30, "rr_timeout");
        expq = '{9'h00A, 9'h10B, 9'h03A, 9'h13B, 9'h05A, 9'h15B};
        check_out(0, "rr");
        if (out0.size() == 6) begin
            check("rr_grant0", out0[0].grant, 0);
            check("rr_grant3", out0[2].grant, 3);
            check("rr_grant5", out0[4].grant, 5);
            check("rr_beat_gap", out0[1].cyc - out0[0].cyc, 1);
            check("rr_pkt_cycles_a", out0[2].cyc - out0[0].cyc, 3);
            check("rr_pkt_cycles_b", out0[4].cyc - out0[2].cyc, 3);
        end
        idle(3); out0.delete();

        // Packet lock: channel 2 holds the grant across a valid gap
        q0[2].push_back(9'h021); q0[2].push_back(9'h022);
        q0[2].push_back(9'h023); q0[2].push_back(9'h124);
        tick();
        q0[1].push_back(9'h011); q0[1].push_back(9'h112);
        t = 0;
        while (q0[2].size() > 2 && t < 10) begin tick(); t++; end
        check("lock_two_beats", q0[2].size(), 2);
        hold0[2] = 1'b1;
        tick();
        check("lock_ready1", if0.ready_o[1], 0);
        check("lock_grant_gap", if0.grant_o, 2);
        tick();
        hold0[2] = 1'b0;
        run_until(0, 6, 30, "lock_timeout");
        expq = '{9'h021, 9'h022, 9'h023, 9'h124, 9'h011, 9'h112};
        check_out(0, "lock");
        if (out0.size() == 6) check("lock_grant1", out0[4].grant, 1);
        idle(3); out0.delete();

        // Backpressure mid-packet on channel 4
        for (int i = 1; i <= 5; i++) q0[4].push_back({(i == 5), 8'h40 + 8'(i)});
        run_until(0, 2, 10, "bp_start_timeout");
        if0.ready_i = 1'b0;
        check("bp_data_at_stall", if0.data_o, 8'h43);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bp_hold_data", if0.data_o, 8'h43);
            check("bp_hold_last", if0.last_o, 0);
            check("bp_hold_valid", if0.valid_o, 1);
            check("bp_ready_low", if0.ready_o, 0);
        end
        if0.ready_i = 1'b1;
        run_until(0, 5, 20, "bp_timeout");
        idle(4);
        expq = '{9'h041, 9'h042, 9'h043, 9'h044, 9'h145};
        check_out(0, "bp");
        out0.delete();

        // External select: channel 4 packet, select moves to 2 mid-packet
        if1.select_i = 3'd4;
        q1[4].push_back(9'h041); q1[4].push_back(9'h042); q1[4].push_back(9'h143);
        q1[2].push_back(9'h021); q1[2].push_back(9'h122);
        idle(3);
        if1.select_i = 3'd2;
        run_until(1, 5, 20, "sel_timeout");
        expq = '{9'h041, 9'h042, 9'h143, 9'h021, 9'h122};
        check_out(1, "sel");
        if (out1.size() == 5) begin
            check("sel_grant4", out1[0].grant, 4);
            check("sel_grant2", out1[3].grant, 2);
        end
        // Select points at a silent channel while channel 3 requests
        if1.select_i = 3'd6;
        q1[3].push_back(9'h131);
        idle(5);
        check("sel_idle_valid", if1.valid_o, 0);
        check("sel_idle_ready", if1.ready_o, 0);
        check("sel_idle_grant", if1.grant_o, 2);
        check("sel_idle_count", out1.size(), 5);
        if1.select_i = 3'd3;
        run_until(1, 6, 10, "sel3_timeout");
        if (out1.size() == 6) check("sel3_beat", {out1[5].last, out1[5].data}, 9'h131);

        // Reset in the middle of a channel-3 packet with channel 0 also requesting
        q0[3].push_back(9'h031); q0[3].push_back(9'h032);
        q0[3].push_back(9'h033); q0[3].push_back(9'h134);
        tick();
        q0[0].push_back(9'h001); q0[0].push_back(9'h102);
        t = 0;
        while (q0[3].size() > 2 && t < 10) begin tick(); t++; end
        check("mid_two_beats", q0[3].size(), 2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_valid", if0.valid_o, 0);
        check("mid_rst_ready", if0.ready_o, 0);
        check("mid_rst_grant", if0.grant_o, 0);
        out0.delete();
        run_until(0, 4, 30, "mid_timeout");
        expq = '{9'h001, 9'h102, 9'h033, 9'h134};
        check_out(0, "mid");
        if (out0.size() == 4) begin
            check("mid_grant0", out0[0].grant, 0);
            check("mid_grant3", out0[2].grant, 3);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
